// File: rtl/sum_display_driver.sv
// sum_display_driver
// Latches a 5-bit adder sum, converts it to two BCD digits and scans them
// onto a two-digit common-anode 7-segment display. A one-cycle blank gap
// separates the digit periods. Leading-zero suppression applies to the
// tens digit.
module sum_display_driver #(
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] sum_in,
    input  logic       load,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       busy
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic [1:0] AN_POL  = SEG_ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        S_ONES  = 2'd0,
        S_GAP_T = 2'd1,
        S_TENS  = 2'd2,
        S_GAP_O = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_value;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_seg;
    logic [1:0]       r_an;

    logic [3:0]       w_bcd_tens;
    logic [3:0]       w_bcd_ones;
    logic             w_term;
    logic [6:0]       w_seg_ah;
    logic [1:0]       w_an_ah;

    // Active-high segment pattern {g,f,e,d,c,b,a} for a decimal digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_term = (r_cnt == CNT_LAST);

    // Binary to BCD for the 0..31 range by threshold comparison.
    always_comb begin
        w_bcd_tens = 4'd0;
        w_bcd_ones = 4'(r_value);
        if (r_value >= 5'd30) begin
            w_bcd_tens = 4'd3;
            w_bcd_ones = 4'(r_value - 5'd30);
        end else if (r_value >= 5'd20) begin
            w_bcd_tens = 4'd2;
            w_bcd_ones = 4'(r_value - 5'd20);
        end else if (r_value >= 5'd10) begin
            w_bcd_tens = 4'd1;
            w_bcd_ones = 4'(r_value - 5'd10);
        end
    end

    // Capture pipeline: latch the sum on load, update digits one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_busy  <= 1'b0;
            r_tens  <= '0;
            r_ones  <= '0;
        end else begin
            r_busy <= load;
            if (load) begin
                r_value <= sum_in;
            end
            if (r_busy) begin
                r_tens <= w_bcd_tens;
                r_ones <= w_bcd_ones;
            end
        end
    end

    // Refresh counter: runs during digit periods, held at zero in the gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_GAP_T || r_state == S_GAP_O || w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Scan FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ONES;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scan FSM next state and active-high display pattern for the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_seg_ah    = '0;
        w_an_ah     = '0;
        case (r_state)
            S_ONES: begin
                w_seg_ah = seg_encode(r_ones);
                w_an_ah  = 2'b01;
                if (w_term) begin
                    w_state_nxt = S_GAP_T;
                end
            end
            S_GAP_T: begin
                w_state_nxt = S_TENS;
            end
            S_TENS: begin
                w_seg_ah = seg_encode(r_tens);
                w_an_ah  = (r_tens != 4'd0) ? 2'b10 : 2'b00;
                if (w_term) begin
                    w_state_nxt = S_GAP_O;
                end
            end
            S_GAP_O: begin
                w_state_nxt = S_ONES;
            end
            default: begin
                w_state_nxt = S_ONES;
            end
        endcase
        if (blank) begin
            w_an_ah = '0;
        end
    end

    // Output registers with polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_POL;
            r_an  <= AN_POL;
        end else begin
            r_seg <= w_seg_ah ^ SEG_POL;
            r_an  <= w_an_ah ^ AN_POL;
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign busy = r_busy;

endmodule

// File: tb/tb_sum_display_driver.sv
// Self-checking bench for sum_display_driver (REFRESH_DIV=4, active-low).
module tb_sum_display_driver;

    logic       clk;
    logic       rst_n;
    logic [4:0] sum_in;
    logic       load;
    logic       blank;
    logic [6:0] seg;
    logic [1:0] an;
    logic       busy;

    int checks = 0;
    int errors = 0;

    sum_display_driver #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sum_in (sum_in),
        .load   (load),
        .blank  (blank),
        .seg    (seg),
        .an     (an),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle vector after reset release: blank applied before the edge,
    // expected outputs sampled after it.
    typedef struct {
        logic       blank;
        logic [6:0] exp_seg;
        logic [1:0] exp_an;
    } cyc_vec_t;

    // Digit vector: loaded value and the active-low patterns it must show.
    typedef struct {
        logic [4:0] sum;
        logic [6:0] ones_seg;
        logic [6:0] tens_seg;
        logic       tens_lit;
    } dig_vec_t;

    cyc_vec_t cyc_tab[11];
    dig_vec_t dig_tab[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [4:0] v);
        @(negedge clk);
        load   = 1'b1;
        sum_in = v;
        @(negedge clk);
        load = 1'b0;
        chk("busy_after_load", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_cleared", {31'd0, busy}, 32'd0);
    endtask

    // Watches one full scan period and checks what each digit position shows.
    task automatic observe(input dig_vec_t dv);
        logic       saw_ones;
        logic       saw_tens;
        logic       bad_an;
        logic [6:0] o_seg;
        logic [6:0] t_seg;
        saw_ones = 1'b0;
        saw_tens = 1'b0;
        bad_an   = 1'b0;
        o_seg    = '0;
        t_seg    = '0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (an == 2'b10) begin
                saw_ones = 1'b1;
                o_seg    = seg;
            end else if (an == 2'b01) begin
                saw_tens = 1'b1;
                t_seg    = seg;
            end else if (an == 2'b00) begin
                bad_an = 1'b1;
            end
        end
        chk("ones_lit", {31'd0, saw_ones}, 32'd1);
        chk("ones_seg", {25'd0, o_seg}, {25'd0, dv.ones_seg});
        chk("tens_lit", {31'd0, saw_tens}, {31'd0, dv.tens_lit});
        if (dv.tens_lit) chk("tens_seg", {25'd0, t_seg}, {25'd0, dv.tens_seg});
        chk("no_double_anode", {31'd0, bad_an}, 32'd0);
    endtask

    initial begin
        cyc_tab[0]  = '{1'b0, 7'h40, 2'b10};
        cyc_tab[1]  = '{1'b1, 7'h40, 2'b11};
        cyc_tab[2]  = '{1'b1, 7'h40, 2'b11};
        cyc_tab[3]  = '{1'b0, 7'h40, 2'b10};
        cyc_tab[4]  = '{1'b0, 7'h7F, 2'b11};
        cyc_tab[5]  = '{1'b0, 7'h40, 2'b11};
        cyc_tab[6]  = '{1'b0, 7'h40, 2'b11};
        cyc_tab[7]  = '{1'b0, 7'h40, 2'b11};
        cyc_tab[8]  = '{1'b0, 7'h40, 2'b11};
        cyc_tab[9]  = '{1'b0, 7'h7F, 2'b11};
        cyc_tab[10] = '{1'b0, 7'h40, 2'b10};

        dig_tab[0] = '{5'd27, 7'h78, 7'h24, 1'b1};
        dig_tab[1] = '{5'd31, 7'h79, 7'h30, 1'b1};
        dig_tab[2] = '{5'd30, 7'h40, 7'h30, 1'b1};
        dig_tab[3] = '{5'd9,  7'h10, 7'h00, 1'b0};
        dig_tab[4] = '{5'd0,  7'h40, 7'h00, 1'b0};

        rst_n  = 1'b0;
        load   = 1'b0;
        blank  = 1'b0;
        sum_in = '0;
        #22;
        chk("reset_seg", {25'd0, seg}, 32'h7F);
        chk("reset_an", {30'd0, an}, 32'h3);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Release at a falling edge, then step through the scan cycle by cycle.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            blank = cyc_tab[i].blank;
            @(negedge clk);
            chk($sformatf("cyc%0d_seg", i + 1), {25'd0, seg}, {25'd0, cyc_tab[i].exp_seg});
            chk($sformatf("cyc%0d_an", i + 1), {30'd0, an}, {30'd0, cyc_tab[i].exp_an});
        end
        blank = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_load(dig_tab[i].sum);
            observe(dig_tab[i]);
        end

        // Back-to-back loads: only the second value survives.
        @(negedge clk);
        load   = 1'b1;
        sum_in = 5'd12;
        @(negedge clk);
        chk("b2b_busy1", {31'd0, busy}, 32'd1);
        sum_in = 5'd18;
        @(negedge clk);
        chk("b2b_busy2", {31'd0, busy}, 32'd1);
        load = 1'b0;
        @(negedge clk);
        chk("b2b_busy_clr", {31'd0, busy}, 32'd0);
        observe('{5'd18, 7'h00, 7'h79, 1'b1});

        // Asynchronous reset in the middle of a tens period.
        do_load(5'd27);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 30 && !found; i++) begin
                @(negedge clk);
                if (an == 2'b01) found = 1'b1;
            end
            chk("tens_period_seen", {31'd0, found}, 32'd1);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {30'd0, an}, 32'h3);
        chk("async_rst_seg", {25'd0, seg}, 32'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_an", {30'd0, an}, 32'h2);
        chk("post_rst_seg", {25'd0, seg}, 32'h40);
        observe(dig_tab[4]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_display_driver.md
Name: sum_display_driver

Overview:
- Consumes the 5-bit sum from the 4-bit adder stage and shows it as a two-digit decimal value (0-31) on a time-multiplexed two-digit common-anode 7-segment display.
- Latches the sum on a load strobe, converts it to BCD, and scans the digits with a refresh counter and a small scan FSM.
- Inserts a one-cycle anode blanking gap between digits to prevent ghosting.
- Sits between the adder output and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit (must be >= 2; use 4 in simulation).
- SEG_ACTIVE_LOW, 1, 1 = segment and anode outputs are active-low; 0 = active-high.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- sum_in  input  5  adder sum, unsigned 0..31
- load  input  1  one-cycle strobe; capture sum_in on this clock edge
- blank  input  1  level; 1 forces all anodes off while scanning continues
- seg  output  7  segments {g,f,e,d,c,b,a}, registered
- an  output  2  anodes, an[0] = ones, an[1] = tens, registered
- busy  output  1  high the cycle after load while BCD is being updated

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state resets immediately on rst_n low, independent of clk.
- Reset values:
  - value_q = 0, tens_q = 0, ones_q = 0, refresh counter = 0, state = S_ONES, busy = 0.
  - seg = all off (7'h7F when SEG_ACTIVE_LOW=1, else 7'h00); an = all off (2'b11 when active-low, else 2'b00).
- Capture path:
  - Cycle N with load=1: value_q <= sum_in, busy <= 1.
  - Cycle N+1: tens_q/ones_q <= BCD(value_q), busy <= 0. New digits appear from the next displayed digit period.
  - load during busy=1 recaptures, and the pipeline restarts from that load.
- BCD rules:
  - tens = 3 if v>=30, 2 if v>=20, 1 if v>=10, else 0; ones = v - 10*tens.
  - 5-bit input, so 31 yields tens=3, ones=1. No overflow indication.
- Segment encoding, active-high, digits 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F. When SEG_ACTIVE_LOW=1, seg and an are bitwise inverted.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Terminal count (REFRESH_DIV-1) advances the FSM.
- Scan FSM states:
  - S_ONES: an[0] on, seg = ones_q. At terminal count -> S_GAP_T.
  - S_GAP_T: both anodes off for exactly one cycle, seg = all off; counter reset to 0. Next -> S_TENS.
  - S_TENS: an[1] on, seg = tens_q. Leading-zero suppression: when tens_q==0, an[1] stays off. At terminal count -> S_GAP_O.
  - S_GAP_O: one cycle all off, counter reset to 0. Next -> S_ONES.
- Output timing: seg/an are registered from state and digits, so they lag state by one cycle. The first cycle after reset release drives ones digit "0".
- blank=1: an forced off on the next edge; FSM and counter keep running; seg still driven. Deasserting blank restores an on the next edge.
- Reset mid-scan: outputs go off immediately; scan restarts in S_ONES with the counter at 0 and the displayed value 0.
- load coinciding with terminal count: both actions occur; the tens digit of the new value appears one BCD cycle later.

Test Plan:
- REFRESH_DIV=4, reset release with no load -> an=2'b10 (ones on) with seg=7'h40 ("0") for 4 cycles, then an=2'b11 for 1 cycle; tens never lit (leading zero); scan period 10 cycles.
- load with sum_in=5'd27 -> busy high one cycle; ones period shows seg=~7'h07 ("7"), tens period an=2'b01 with seg=~7'h5B ("2").
- sum_in=31 and sum_in=30 -> digit pairs (3,1) and (3,0); sum_in=9 -> tens anode never asserted.
- Back-to-back loads of 12 then 18 on consecutive cycles -> only 18 displayed; busy high for the cycle after each load.
- blank asserted mid-ones period -> an=2'b11 on the next edge while the counter continues; deassert -> correct digit resumes at the expected scan phase.
- rst_n pulsed low mid-tens period, asynchronous (between edges) -> seg/an go off without waiting for a clock edge; after release, display shows "0" starting in S_ONES.
